// File: rtl/tpu_pkg.sv
// tpu_pkg: shared weight-path types and constants
//   wl_state_t : weight_load_ctrl sequencer states
//   WL_DEPTH   : rows per weight FIFO column, shared by the controller and the FIFO
package tpu_pkg;
  typedef enum logic [2:0] {WL_IDLE, WL_FILL, WL_PAD, WL_DRAIN, WL_DONE} wl_state_t;
  localparam int WL_DEPTH = 4;
endpackage

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: fills a 2-column weight FIFO from a byte stream, then drains it into the MMU
//   clk, reset (async, active-high)
//   start, abort              : tile commands (start in IDLE, abort in FILL)
//   wt_valid, wt_data/wt_ready: upstream byte stream
//   push_col0/1, fifo_data    : FIFO write side (combinational from the handshake)
//   pop, mmu_load_en, load_row: FIFO drain and MMU capture window
//   busy, done, aborted       : status
module weight_load_ctrl
  import tpu_pkg::*;
#(
  parameter int DEPTH  = WL_DEPTH,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   wt_valid,
  input  logic [DATA_W-1:0]      wt_data,
  output logic                   wt_ready,
  output logic                   push_col0,
  output logic                   push_col1,
  output logic [DATA_W-1:0]      fifo_data,
  output logic                   pop,
  output logic                   mmu_load_en,
  output logic [$clog2(DEPTH):0] load_row,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted
);
  localparam int CW = $clog2(2 * DEPTH) + 1;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(2 * DEPTH - 1);
  localparam logic [CW-1:0] ROWS = CW'(DEPTH);
  wl_state_t state;
  logic [CW-1:0] fill_cnt, drain_cnt;
  logic abort_q, xfer, pad;
  // abort takes priority: the byte offered in the abort cycle is dropped
  assign xfer = state == WL_FILL && wt_valid && !abort;
  assign pad = state == WL_PAD;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= WL_IDLE;
      fill_cnt <= '0;
      drain_cnt <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state)
        WL_IDLE: if (start) begin
          state <= WL_FILL;
          fill_cnt <= '0;
          drain_cnt <= '0;
        end
        WL_FILL: if (abort) begin
          state <= fill_cnt == '0 ? WL_IDLE : WL_PAD;
          abort_q <= fill_cnt == '0;
        end else if (wt_valid) begin
          fill_cnt <= fill_cnt + ONE;
          if (fill_cnt == LAST) state <= WL_DRAIN;
        end
        // zero padding keeps both column write pointers level with the read pointers
        WL_PAD: begin
          fill_cnt <= fill_cnt + ONE;
          if (fill_cnt == LAST) begin
            state <= WL_IDLE;
            abort_q <= 1'b1;
          end
        end
        WL_DRAIN: begin
          drain_cnt <= drain_cnt + ONE;
          if (drain_cnt == ROWS) state <= WL_DONE;
        end
        default: state <= WL_IDLE;
      endcase
    end
  assign wt_ready = state == WL_FILL;
  assign push_col0 = (xfer || pad) && !fill_cnt[0];
  assign push_col1 = (xfer || pad) && fill_cnt[0];
  assign fifo_data = state == WL_FILL ? wt_data : '0;
  assign pop = state == WL_DRAIN && drain_cnt < ROWS;
  // one extra capture cycle covers the column-1 skew
  assign mmu_load_en = state == WL_DRAIN;
  assign load_row = mmu_load_en ? drain_cnt[$clog2(DEPTH):0] : '0;
  assign busy = state != WL_IDLE;
  assign done = state == WL_DONE;
  assign aborted = abort_q;
endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: scoreboard bench for weight_load_ctrl
module tb_weight_load_ctrl;
  localparam int K_PUSH0 = 0, K_PUSH1 = 1, K_POP = 2, K_MMU = 3, K_DONE = 4, K_ABORT = 5;
  typedef struct {int k; int v; int c;} ev_t;
  logic clk = 0, reset = 1, start = 0, abort = 0, wt_valid = 0;
  logic [7:0] wt_data = 0;
  logic wt_ready, push_col0, push_col1, pop, mmu_load_en, busy, done, aborted;
  logic [7:0] fifo_data;
  logic [2:0] load_row;
  int cyc = 0, checks = 0, errors = 0;
  ev_t q[$];
  weight_load_ctrl #(.DEPTH(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .wt_valid(wt_valid),
    .wt_data(wt_data), .wt_ready(wt_ready), .push_col0(push_col0), .push_col1(push_col1),
    .fifo_data(fifo_data), .pop(pop), .mmu_load_en(mmu_load_en), .load_row(load_row),
    .busy(busy), .done(done), .aborted(aborted)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic exp_ev(input int k, input int v, input int c);
    q.push_back('{k, v, c});
  endtask
  task automatic cmp(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", n, a, e, cyc);
    end
  endtask
  task automatic chk(input int k, input int v, input int c);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got kind=%0d val=%0h cyc=%0d exp none", k, v, c);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.v != v || e.c != c) begin
        errors++;
        $display("FAIL event got kind=%0d val=%0h cyc=%0d exp kind=%0d val=%0h cyc=%0d",
                 k, v, c, e.k, e.v, e.c);
      end
    end
  endtask
  always @(negedge clk) begin
    if (push_col0) chk(K_PUSH0, int'(fifo_data), cyc);
    if (push_col1) chk(K_PUSH1, int'(fifo_data), cyc);
    if (pop) chk(K_POP, int'(load_row), cyc);
    if (mmu_load_en) chk(K_MMU, int'(load_row), cyc);
    if (done) chk(K_DONE, 0, cyc);
    if (aborted) chk(K_ABORT, 0, cyc);
  end
  task automatic all_zero(input string n);
    cmp(n, int'({wt_ready, push_col0, push_col1, fifo_data, pop, mmu_load_en, load_row,
                 busy, done, aborted}), 0);
  endtask
  task automatic fill_bytes(input logic [7:0] b0, input bit stall);
    start = 1;
    step();
    start = 0;
    cmp("busy_ready_fill", int'({busy, wt_ready}), 3);
    for (int i = 0; i < 8; i++) begin
      wt_valid = 1;
      wt_data = b0 + 8'(i);
      exp_ev(i % 2, int'(b0) + i, cyc);
      step();
      if (stall && i < 7) begin
        wt_valid = 0;
        wt_data = 8'hEE;
        step();
      end
    end
    wt_valid = 0;
  endtask
  task automatic tile(input logic [7:0] b0, input bit stall, input bit noise);
    int t;
    fill_bytes(b0, stall);
    t = cyc;
    for (int r = 0; r < 4; r++) begin
      exp_ev(K_POP, r, t + r);
      exp_ev(K_MMU, r, t + r);
    end
    exp_ev(K_MMU, 4, t + 4);
    exp_ev(K_DONE, 0, t + 5);
    for (int i = 0; i < 6; i++) begin
      if (noise && i == 1) begin
        start = 1;
        abort = 1;
      end
      step();
      start = 0;
      abort = 0;
    end
    cmp("idle_after_tile", int'(busy), 0);
  endtask
  initial begin
    int c;
    step();
    all_zero("reset_state");
    reset = 0;
    step();
    all_zero("idle_state");
    // nominal: start at c, pushes c+1..c+8, drain c+9..c+13, done c+14
    c = cyc;
    tile(8'h11, 0, 0);
    cmp("nominal_len", cyc - c, 15);
    // stalled stream: 7 stall cycles push done to c+21
    c = cyc;
    tile(8'h21, 1, 0);
    cmp("stalled_len", cyc - c, 22);
    // abort after three bytes: five zero pads col1,col0,col1,col0,col1
    c = cyc;
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      wt_valid = 1;
      wt_data = 8'hA1 + 8'(i);
      exp_ev(i % 2, 'hA1 + i, cyc);
      step();
    end
    wt_valid = 0;
    abort = 1;
    step();
    abort = 0;
    for (int i = 0; i < 5; i++) begin
      exp_ev((3 + i) % 2, 0, cyc);
      step();
    end
    exp_ev(K_ABORT, 0, cyc);
    cmp("abort3_cycle", cyc - c, 10);
    step();
    tile(8'h31, 0, 0);
    // abort with nothing filled, valid byte offered in the same cycle is dropped
    start = 1;
    step();
    start = 0;
    abort = 1;
    wt_valid = 1;
    wt_data = 8'h55;
    step();
    abort = 0;
    wt_valid = 0;
    exp_ev(K_ABORT, 0, cyc);
    cmp("abort0_idle", int'(busy), 0);
    step();
    // abort coinciding with a transfer after two bytes: six pads from fill_cnt 2
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 2; i++) begin
      wt_valid = 1;
      wt_data = 8'hB1 + 8'(i);
      exp_ev(i % 2, 'hB1 + i, cyc);
      step();
    end
    wt_data = 8'hB3;
    abort = 1;
    step();
    abort = 0;
    wt_valid = 0;
    for (int i = 0; i < 6; i++) begin
      exp_ev(i % 2, 0, cyc);
      step();
    end
    exp_ev(K_ABORT, 0, cyc);
    step();
    // start and abort during DRAIN are ignored
    tile(8'h41, 0, 1);
    // reset at DRAIN cycle 2
    fill_bytes(8'h51, 0);
    c = cyc;
    exp_ev(K_POP, 0, c);
    exp_ev(K_MMU, 0, c);
    exp_ev(K_POP, 1, c + 1);
    exp_ev(K_MMU, 1, c + 1);
    step();
    step();
    reset = 1;
    #1;
    all_zero("async_reset_drain");
    step();
    reset = 0;
    step();
    all_zero("after_reset");
    tile(8'h61, 0, 0);
    step();
    cmp("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
